posit_decoder: RTL
==================

POSIT_DECODER -- requirements
Module: posit_decoder

Interface
REQ-001 SHALL have parameter none; the format is fixed at 32-bit posit, es=3, sign stored raw (sign-magnitude body, no two's complement).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 p_in  input  32  posit word; captured on the accepting edge.
REQ-006 sign_out  output  1  decoded sign (bit 31).
REQ-007 k_out  output  6  signed regime value, range [-31,30].
REQ-008 exp_out  output  3  exponent field.
REQ-009 mantissa_out  output  32  fraction bits, left-aligned (first fraction bit at [31]), unused LSBs zero.
REQ-010 zero_flag  output  1  p_in == 0x00000000.
REQ-011 nar_flag  output  1  p_in == 0x80000000.
REQ-012 done  output  1  one-cycle pulse; results valid from that cycle.

Function
REQ-013 SHALL implement FSM states IDLE, SIGN, REGIME, EXP, MANT, DONE, processing one body bit per cycle from bit 30 down to bit 0.
REQ-014 IDLE: start=1 -> capture p_in, clear bit index to 30, clear working regs, go SIGN; start=0 -> stay, outputs hold last results.
REQ-015 start asserted outside IDLE SHALL be ignored; p_in changes after capture SHALL have no effect.
REQ-016 SIGN: sign_out <= captured bit 31; go REGIME.
REQ-017 REGIME: first body bit sets run polarity; each equal bit increments run count; first opposite bit is consumed as terminator, then go EXP.
REQ-018 k SHALL be run-1 for a run of ones and -run for a run of zeros.
REQ-019 EXP: consume up to 3 bits MSB-first into exp_out[2:0]; then go MANT.
REQ-020 MANT: remaining bits written MSB-first into mantissa_out starting at [31].
REQ-021 Whenever bit 0 is consumed in any state, the FSM SHALL go DONE; fields not reached stay zero (truncated exponent bits are zero, low-order).
REQ-022 Regime running to bit 0 without terminator: ones -> k_out=30; zeros -> k_out=-31.
REQ-023 zero_flag/nar_flag SHALL be computed from the captured word and updated together with the other results; for 0x80000000 sign_out=1, k_out=-31.
REQ-024 Latency fixed: start accepted at edge E0; done=1 for exactly the cycle after edge E0+33; FSM back in IDLE after edge E0+34 (next start accepted there at the earliest).
REQ-025 Outputs SHALL update atomically at the DONE transition and remain stable until the next DONE.
REQ-026 Bit index SHALL be 5 bits and never wrap below 0.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, done=0, sign_out=0, k_out=0, exp_out=0, mantissa_out=0, zero_flag=0, nar_flag=0, index=30, irrespective of clk.
REQ-028 Reset mid-decode SHALL abort the operation with no done pulse; next start after release decodes normally.

Verification
REQ-029 p_in=0x40000000 -> sign 0, k 0, exp 0, mant 0x00000000, done at E0+33.
REQ-030 p_in=0x3FFFFFFF -> sign 0, k -1, exp 7, mant 0xFFFFFFC0.
REQ-031 p_in=0x7FFFFFFF -> k 30, exp 0, mant 0; p_in=0x00000000 -> zero_flag 1, k -31.
REQ-032 p_in=0xC8000000 -> sign 1, k 0, exp 2, mant 0; p_in=0x80000000 -> nar_flag 1, sign 1.
REQ-033 start pulsed again and p_in changed at E0+10 -> ignored, results match first word, single done pulse.
REQ-034 rst low at E0+12 -> all outputs 0, no done; start after release with 0x40000000 -> result per REQ-029.

Source files
------------

// File: rtl/posit_decoder.sv
// -----------------------------------------------------------------------------
// posit_decoder
//   Bit-serial decoder for 32-bit posits with es = 3. The sign is taken raw
//   from bit 31 and the body (bits 30..0) is decoded as it stands, with no
//   two's-complement negation. One body bit is consumed per clock, from
//   bit 30 down to bit 0.
//
//   State sequence:
//     IDLE -> SIGN -> REGIME -> EXP -> MANT -> DONE -> IDLE
//   Consuming bit 0 in any of REGIME, EXP or MANT goes straight to DONE.
//
//   Timing: a start accepted at edge E0 makes done high for the single cycle
//   after edge E0+33. The FSM is back in IDLE after edge E0+34. All result
//   outputs change together at the done edge and then hold until the next
//   done.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst           in   1  asynchronous, active-low reset
//   start         in   1  decode request, sampled only in IDLE
//   p_in          in  32  posit word, captured on the accepting edge
//   sign_out      out  1  raw sign bit (bit 31)
//   k_out         out  6  signed regime value, range -31..30
//   exp_out       out  3  exponent field; truncated bits read as zero
//   mantissa_out  out 32  fraction bits left-aligned at [31], unused LSBs zero
//   zero_flag     out  1  captured word was 0x00000000
//   nar_flag      out  1  captured word was 0x80000000 (NaR)
//   done          out  1  one-cycle pulse; results are valid from that cycle
// -----------------------------------------------------------------------------
module posit_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] p_in,
  output logic        sign_out,
  output logic [5:0]  k_out,
  output logic [2:0]  exp_out,
  output logic [31:0] mantissa_out,
  output logic        zero_flag,
  output logic        nar_flag,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    SIGN,
    REGIME,
    EXP,
    MANT,
    DONE
  } state_t;

  state_t      state_q;

  // Working registers for the decode in flight.
  logic [31:0] word_q;     // captured posit word
  logic [4:0]  idx_q;      // index of the next body bit to consume
  logic        sign_w_q;
  logic        pol_q;      // regime run polarity
  logic [4:0]  run_q;      // regime run length; zero means no bit seen yet
  logic [2:0]  exp_w_q;
  logic [1:0]  e_pos_q;    // next exponent bit to write (2 down to 0)
  logic [31:0] mant_w_q;
  logic [4:0]  m_pos_q;    // next mantissa bit to write (31 downwards)

  // Published results; these registers drive the output ports directly.
  logic        sign_q;
  logic [5:0]  k_q;
  logic [2:0]  exp_q;
  logic [31:0] mant_q;
  logic        zero_q;
  logic        nar_q;
  logic        done_q;

  logic        cur_bit;
  logic        last_bit;
  logic [4:0]  idx_d;
  logic [5:0]  k_d;

  assign cur_bit  = word_q[idx_q];
  assign last_bit = (idx_q == 5'd0);
  // The index stops at zero instead of wrapping to 31.
  assign idx_d    = last_bit ? 5'd0 : idx_q - 5'd1;
  // A run of ones gives k = run-1. A run of zeros gives k = -run.
  assign k_d      = pol_q ? ({1'b0, run_q} - 6'd1) : (6'd0 - {1'b0, run_q});

  // NOTE: every register in this block is assigned with <=. Each branch
  // therefore reads the values from before this edge, so the order of the
  // statements inside a branch has no effect on the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      idx_q    <= 5'd30;
      sign_w_q <= 1'b0;
      pol_q    <= 1'b0;
      run_q    <= '0;
      exp_w_q  <= '0;
      e_pos_q  <= 2'd2;
      mant_w_q <= '0;
      m_pos_q  <= 5'd31;
      sign_q   <= 1'b0;
      k_q      <= '0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      nar_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            word_q   <= p_in;
            idx_q    <= 5'd30;
            sign_w_q <= 1'b0;
            pol_q    <= 1'b0;
            run_q    <= '0;
            exp_w_q  <= '0;
            e_pos_q  <= 2'd2;
            mant_w_q <= '0;
            m_pos_q  <= 5'd31;
            state_q  <= SIGN;
          end
        end

        SIGN: begin
          sign_w_q <= word_q[31];
          state_q  <= REGIME;
        end

        REGIME: begin
          idx_q <= idx_d;
          if (run_q == 5'd0) begin
            // The first body bit sets the polarity of the run.
            pol_q <= cur_bit;
            run_q <= 5'd1;
            if (last_bit) state_q <= DONE;
          end else if (cur_bit == pol_q) begin
            run_q <= run_q + 5'd1;
            if (last_bit) state_q <= DONE;
          end else begin
            // First opposite bit: the terminator is consumed here.
            state_q <= last_bit ? DONE : EXP;
          end
        end

        EXP: begin
          idx_q            <= idx_d;
          exp_w_q[e_pos_q] <= cur_bit;
          e_pos_q          <= e_pos_q - 2'd1;
          if (last_bit)              state_q <= DONE;
          else if (e_pos_q == 2'd0)  state_q <= MANT;
        end

        MANT: begin
          idx_q             <= idx_d;
          mant_w_q[m_pos_q] <= cur_bit;
          m_pos_q           <= m_pos_q - 5'd1;
          if (last_bit) state_q <= DONE;
        end

        DONE: begin
          if (!done_q) begin
            // First DONE cycle: publish every field together.
            sign_q <= sign_w_q;
            k_q    <= k_d;
            exp_q  <= exp_w_q;
            mant_q <= mant_w_q;
            zero_q <= (word_q == 32'h0000_0000);
            nar_q  <= (word_q == 32'h8000_0000);
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign sign_out     = sign_q;
  assign k_out        = k_q;
  assign exp_out      = exp_q;
  assign mantissa_out = mant_q;
  assign zero_flag    = zero_q;
  assign nar_flag     = nar_q;
  assign done         = done_q;

endmodule
